// File: rtl/n_2_hs_player.sv
// Hand-sign player: queues finger counts (1-10) in a small FIFO and shows each
// as a 5-bit hand-sign code for HOLD_CYCLES, followed by GAP_CYCLES blank cycles.
module n_2_hs_player #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] n_in,
  input  logic       n_valid,
  output logic       n_ready,
  output logic [4:0] hs,
  output logic       hs_valid,
  output logic       err,
  output logic       busy
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [4:0]    hs_q, hs_d;
  logic          hs_valid_q, hs_valid_d;
  logic          err_q;

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          empty, full, in_range, accept, push, pop, next_slot;
  logic [3:0]    head;

  function automatic logic [4:0] encode(input logic [3:0] n);
    case (n)
      4'd1:    encode = 5'b00001;
      4'd2:    encode = 5'b00011;
      4'd3:    encode = 5'b00111;
      4'd4:    encode = 5'b01111;
      4'd5:    encode = 5'b11111;
      4'd6:    encode = 5'b11110;
      4'd7:    encode = 5'b11100;
      4'd8:    encode = 5'b11000;
      4'd9:    encode = 5'b10000;
      default: encode = 5'b00000;
    endcase
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_range = (n_in != 4'd0) && (n_in <= 4'd10);
  assign accept   = n_valid && !full;
  assign push     = accept && in_range;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= n_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= IDLE;
      tmr_q      <= '0;
      hs_q       <= '0;
      hs_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      hs_q       <= hs_d;
      hs_valid_q <= hs_valid_d;
      err_q      <= accept && !in_range;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    hs_d       = hs_q;
    hs_valid_d = hs_valid_q;
    pop        = 1'b0;
    next_slot  = 1'b0;
    case (state_q)
      IDLE: next_slot = 1'b1;
      SHOW: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (GAP_CYCLES > 0) begin
          hs_d       = 5'b00000;
          hs_valid_d = 1'b0;
          tmr_d      = GAP_LOAD;
          state_d    = GAP;
        end else begin
          next_slot = 1'b1;
        end
      end
      GAP: begin
        if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
        else             next_slot = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Back-to-back slots load straight into SHOW so the period stays fixed.
    if (next_slot) begin
      if (!empty) begin
        pop        = 1'b1;
        hs_d       = encode(head);
        hs_valid_d = 1'b1;
        tmr_d      = HOLD_LOAD;
        state_d    = SHOW;
      end else begin
        hs_d       = 5'b00000;
        hs_valid_d = 1'b0;
        state_d    = IDLE;
      end
    end
  end

  assign n_ready  = !full;
  assign hs       = hs_q;
  assign hs_valid = hs_valid_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE) || !empty;

endmodule

// File: doc/n_2_hs_player.md
# n_2_hs_player

Converts queued 4-bit finger counts (1–10) into the team's 5-bit hand-sign code. It presents each sign on `hs` for a fixed number of cycles, separated by a blank gap. It is the transmit-side counterpart of the hand-sign-to-number converter and drives the hand-sign bus consumed by it. Input is a valid/ready stream buffered in a small FIFO, so producers can burst several counts.

## Interface
- `HOLD_CYCLES`, 4: cycles each sign is shown with `hs_valid` high; legal range ≥1.
- `GAP_CYCLES`, 1: blank cycles after each sign; legal range ≥0.
- `FIFO_DEPTH`, 4: count-queue entries; must be a power of two, ≥2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `n_in` input 4: count to display (unsigned).
- `n_valid` input 1: `n_in` is offered.
- `n_ready` output 1: block accepts `n_in` this cycle; equals !fifo_full.
- `hs` output 5: hand-sign code; 5'b00000 whenever `hs_valid` is low.
- `hs_valid` output 1: `hs` carries a sign.
- `err` output 1: one-cycle pulse, an out-of-range count was accepted.
- `busy` output 1: state ≠ IDLE or FIFO non-empty.

## Operation
- Encoding: 1→00001, 2→00011, 3→00111, 4→01111, 5→11111, 6→11110, 7→11100, 8→11000, 9→10000, 10→00000.
- Because 10 encodes as 00000, `hs_valid` is the only way to tell sign 10 from blank.
- Accept: `n_valid && n_ready` at a rising edge.
  - Counts 1–10 are pushed into the FIFO.
  - Counts 0 and 11–15 are consumed but not stored; `err` is high the following cycle only.
- `n_ready` depends only on FIFO occupancy, never on `n_valid`.
  - A pop in the same cycle does not raise `n_ready` when the FIFO is full.
  - A full FIFO does not accept, so it never raises `err`.
- The FSM has three states: IDLE, SHOW, GAP. It uses a down-counter `tmr` sized for max(HOLD_CYCLES, GAP_CYCLES).
  - **IDLE:** if the FIFO is non-empty, pop the head, register `hs` = encode(head), set `hs_valid` = 1, `tmr` = HOLD_CYCLES−1, and go to SHOW.
  - **SHOW:** if `tmr` ≠ 0, decrement it. Otherwise end the slot:
    - If GAP_CYCLES > 0: set `hs` = 0, `hs_valid` = 0, `tmr` = GAP_CYCLES−1, go to GAP.
    - If GAP_CYCLES = 0: apply the next-slot rule.
  - **GAP:** if `tmr` ≠ 0, decrement it. Otherwise apply the next-slot rule.
  - **Next-slot rule:** if the FIFO is non-empty, pop and load as in IDLE, going straight to SHOW with no idle cycle. Otherwise drive `hs` = 0, `hs_valid` = 0 and go to IDLE.
- The FIFO is a circular buffer with read/write pointers one bit wider than log2(FIFO_DEPTH) for the full/empty test. Pointers wrap modulo 2·FIFO_DEPTH.
- Push and pop in the same edge are allowed when the FIFO is neither empty nor full; occupancy is unchanged.
- Pop from an empty FIFO never occurs: the FSM tests empty before popping.
- Output order equals accept order. No count is dropped except out-of-range ones.

## Timing
- Reset values:
  - Outputs: `hs` = 0, `hs_valid` = 0, `err` = 0, `busy` = 0, `n_ready` = 1.
  - Internal: FIFO empty, state IDLE, `tmr` = 0.
- Reset asserted mid-operation flushes the FIFO and any sign in progress immediately, without waiting for a clock edge.
- Latency: a count accepted at edge E0 while IDLE with the FIFO empty appears on `hs` with `hs_valid` = 1 after edge E0+1.
- `hs_valid` stays high for exactly HOLD_CYCLES cycles and is then low for exactly GAP_CYCLES cycles.
- With a continuously fed FIFO, the sign period is exactly HOLD_CYCLES + GAP_CYCLES cycles.
- `hs`, `hs_valid` and `err` are registered outputs and are glitch-free.

## Test plan
- **Reset:** assert `rst` asynchronously mid-SHOW of sign 7 → `hs` = 00000, `hs_valid` = 0, `busy` = 0, `n_ready` = 1 before the next edge. After release, the earlier queued counts never appear.
- **Single count, defaults:** n=3 accepted at E0 → `hs` = 00111 with `hs_valid` = 1 for cycles E0+1..E0+4, then 1 cycle with `hs_valid` = 0, then IDLE; `busy` falls with the return to IDLE.
- **Burst and backpressure, defaults:** offer 1,5,9,10,6,2 back-to-back.
  - 1–6 are accepted on consecutive edges E0..E4; `n_ready` goes low after E4.
  - 2 is accepted one edge after the first pop following the end of the 1/5 slot.
  - `hs` sequence is 00001, 11111, 10000, 00000 (with `hs_valid` = 1), 11110, 00011. Each is held 4 cycles with 1-cycle gaps.
- **Out-of-range counts:** n_in = 0, then 11, then 15 → `err` pulses 1 cycle after each accept, `hs_valid` never rises, FIFO stays empty.
- **GAP_CYCLES = 0, HOLD_CYCLES = 2:** counts 4, 8 → `hs` = 01111 for 2 cycles, then 11000 for 2 cycles, with `hs_valid` continuously high for 4 cycles.
- **FIFO pointer wrap:** stream 40 random valid counts with random `n_valid` gaps → output matches input order exactly, and `n_ready` is never high when occupancy = FIFO_DEPTH.
